// File: rtl/dms_seq_ctrl.sv
// Sequencing controller for the decryption message system: loads the (n, d, N) key frame,
// frames serial ciphertext blocks, hands them to the modexp datapath and serialises plaintext.
module dms_seq_ctrl #(
  parameter int NW   = 4,
  parameter int KMAX = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            str,
  input  logic            mode,
  output logic [KMAX-1:0] key_d,
  output logic [KMAX-1:0] key_n,
  output logic [5:0]      key_len,
  output logic            key_valid,
  output logic            cfg_err,
  output logic [KMAX-1:0] ct_data,
  output logic            ct_valid,
  input  logic            ct_ready,
  input  logic [KMAX-1:0] pt_data,
  input  logic            pt_valid,
  output logic            pt_ready,
  output logic            msg,
  output logic            frame,
  output logic            busy,
  output logic [3:0]      fsm_state
);

  localparam int LW = $clog2(KMAX);
  localparam logic [NW-1:0] N_MAX = NW'(LW);

  localparam logic [3:0] IDLE    = 4'd0;
  localparam logic [3:0] LOAD_N  = 4'd1;
  localparam logic [3:0] LOAD_D  = 4'd2;
  localparam logic [3:0] LOAD_CN = 4'd3;
  localparam logic [3:0] KEY_OK  = 4'd4;
  localparam logic [3:0] RX_CT   = 4'd5;
  localparam logic [3:0] ISSUE   = 4'd6;
  localparam logic [3:0] WAIT_PT = 4'd7;
  localparam logic [3:0] TX_PT   = 4'd8;

  // Handshakes: a block moves on ct_valid&ct_ready, plaintext on pt_valid&pt_ready, both
  // sampled at the rising edge; valid stays high and data stays stable until that edge.

  logic [3:0]      state;
  logic            mode_q;
  logic [5:0]      bit_cnt;
  logic [NW-1:0]   n_sh;
  logic [KMAX-1:0] pt_q;

  logic            cfg_start;
  logic [NW-1:0]   n_next;
  logic [5:0]      last_idx;
  logic            bit_last;
  logic [LW-1:0]   tx_idx;

  assign cfg_start = mode && !mode_q;
  assign n_next    = {n_sh[NW-2:0], str};
  assign last_idx  = key_len - 6'd1;
  assign bit_last  = (bit_cnt == last_idx);
  assign tx_idx    = LW'(last_idx - bit_cnt);
  assign busy      = (state == ISSUE) || (state == WAIT_PT) || (state == TX_PT);
  assign fsm_state = state;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      mode_q    <= 1'b0;
      bit_cnt   <= '0;
      n_sh      <= '0;
      pt_q      <= '0;
      key_d     <= '0;
      key_n     <= '0;
      key_len   <= '0;
      key_valid <= 1'b0;
      cfg_err   <= 1'b0;
      ct_data   <= '0;
      ct_valid  <= 1'b0;
      pt_ready  <= 1'b0;
      msg       <= 1'b0;
      frame     <= 1'b0;
    end else begin
      mode_q <= mode;
      // A rising mode edge in RX_CT drops the partial block and reloads the key.
      if (cfg_start && (state == IDLE || state == KEY_OK || state == RX_CT)) begin
        n_sh      <= {{(NW-1){1'b0}}, str};
        bit_cnt   <= 6'd1;
        key_valid <= 1'b0;
        cfg_err   <= 1'b0;
        key_d     <= '0;
        key_n     <= '0;
        key_len   <= '0;
        ct_data   <= '0;
        state     <= LOAD_N;
      end else begin
        case (state)
          LOAD_N, LOAD_D, LOAD_CN: begin
            if (!mode) begin
              cfg_err <= 1'b1;
              key_d   <= '0;
              key_n   <= '0;
              key_len <= '0;
              bit_cnt <= '0;
              state   <= IDLE;
            end else if (state == LOAD_N) begin
              n_sh    <= n_next;
              bit_cnt <= bit_cnt + 6'd1;
              if (bit_cnt == 6'(NW - 1)) begin
                bit_cnt <= '0;
                if (n_next != '0 && n_next <= N_MAX) begin
                  key_len <= 6'd1 << n_next;
                  state   <= LOAD_D;
                end else begin
                  cfg_err <= 1'b1;
                  state   <= IDLE;
                end
              end
            end else if (state == LOAD_D) begin
              key_d   <= {key_d[KMAX-2:0], str};
              bit_cnt <= bit_cnt + 6'd1;
              if (bit_last) begin
                bit_cnt <= '0;
                state   <= LOAD_CN;
              end
            end else begin
              key_n   <= {key_n[KMAX-2:0], str};
              bit_cnt <= bit_cnt + 6'd1;
              if (bit_last) begin
                bit_cnt   <= '0;
                key_valid <= 1'b1;
                state     <= KEY_OK;
              end
            end
          end
          KEY_OK: begin
            if (!mode && str) begin
              bit_cnt <= '0;
              ct_data <= '0;
              state   <= RX_CT;
            end
          end
          RX_CT: begin
            if (!mode) begin
              ct_data <= {ct_data[KMAX-2:0], str};
              bit_cnt <= bit_cnt + 6'd1;
              if (bit_last) begin
                bit_cnt  <= '0;
                ct_valid <= 1'b1;
                state    <= ISSUE;
              end
            end
          end
          ISSUE: begin
            if (ct_ready) begin
              ct_valid <= 1'b0;
              pt_ready <= 1'b1;
              state    <= WAIT_PT;
            end
          end
          WAIT_PT: begin
            if (pt_valid) begin
              pt_q     <= pt_data;
              pt_ready <= 1'b0;
              bit_cnt  <= '0;
              state    <= TX_PT;
            end
          end
          TX_PT: begin
            if (bit_cnt == key_len) begin
              frame   <= 1'b0;
              msg     <= 1'b0;
              bit_cnt <= '0;
              state   <= KEY_OK;
            end else begin
              frame   <= 1'b1;
              msg     <= pt_q[tx_idx];
              bit_cnt <= bit_cnt + 6'd1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
